// File: rtl/elbeth_memory_arbiter.sv
// ---------------------------------------------------------------------------
// elbeth_memory_arbiter
//
// Shares a single memory port between the ELBETH instruction-fetch side (I)
// and data-access side (D). One request is granted at a time; simultaneous
// requests alternate (round robin) based on the side granted last. A granted
// request is range/alignment checked, then run on the memory port with an
// optional bus timeout. The outcome goes back to the granted side as a
// one-cycle ready or error pulse.
//
// Parameters
//   ADDR_W   memory word-address width
//   TIMEOUT  max ACCESS cycles without mem_ready/mem_error (0 = wait forever)
//
// Ports
//   clk, rst                          clock, async active-high reset
//   imem_en, imem_addr                fetch request and byte address
//   imem_rdata, imem_ready, imem_error  fetch result and completion pulses
//   dmem_en, dmem_addr, dmem_wdata, dmem_rw  data request (rw=0 -> read)
//   dmem_rdata, dmem_ready, dmem_error  data result and completion pulses
//   mem_en, mem_addr, mem_wdata, mem_rw  memory port request
//   mem_rdata, mem_ready, mem_error   memory port response
// ---------------------------------------------------------------------------
module elbeth_memory_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              imem_en,
   input  logic [31:0]       imem_addr,
   output logic [31:0]       imem_rdata,
   output logic              imem_ready,
   output logic              imem_error,

   input  logic              dmem_en,
   input  logic [31:0]       dmem_addr,
   input  logic [31:0]       dmem_wdata,
   input  logic [3:0]        dmem_rw,
   output logic [31:0]       dmem_rdata,
   output logic              dmem_ready,
   output logic              dmem_error,

   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_rw,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   input  logic              mem_error
);

   // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } side_t;

   state_t             state_q, state_n;
   side_t              last_grant_q, last_grant_n;
   side_t              owner_q, owner_n;
   logic               resp_err_q, resp_err_n;
   logic [ADDR_W-1:0]  addr_q, addr_n;
   logic [31:0]        wdata_q, wdata_n;
   logic [3:0]         rw_q, rw_n;
   logic [31:0]        rdata_q, rdata_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic               pick_d;
   logic               grant_bad;

   // The data side's byte offset is irrelevant for word-granular accesses.
   logic               unused_dmem_lsb;
   assign unused_dmem_lsb = ^dmem_addr[1:0];

   // D wins when it is the only requester, or when both request and I was
   // granted last time; otherwise I wins.
   assign pick_d = dmem_en && (!imem_en || (last_grant_q == GRANT_I));

   // State and datapath registers. Everything the outputs are built from lives
   // here, so requester inputs never reach the memory port combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_I;
         owner_q      <= GRANT_I;
         resp_err_q   <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rw_q         <= '0;
         rdata_q      <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_n;
         last_grant_q <= last_grant_n;
         owner_q      <= owner_n;
         resp_err_q   <= resp_err_n;
         addr_q       <= addr_n;
         wdata_q      <= wdata_n;
         rw_q         <= rw_n;
         rdata_q      <= rdata_n;
         cnt_q        <= cnt_n;
      end
   end

   // Next-state logic: arbitrate and check in IDLE, watch the memory response
   // and timeout in ACCESS, and spend exactly one cycle in RESP.
   always_comb begin
      state_n      = state_q;
      last_grant_n = last_grant_q;
      owner_n      = owner_q;
      resp_err_n   = resp_err_q;
      addr_n       = addr_q;
      wdata_n      = wdata_q;
      rw_n         = rw_q;
      rdata_n      = rdata_q;
      cnt_n        = cnt_q;
      grant_bad    = 1'b0;

      case (state_q)
         IDLE: begin
            if (imem_en || dmem_en) begin
               if (pick_d) begin
                  owner_n   = GRANT_D;
                  addr_n    = dmem_addr[ADDR_W+1:2];
                  wdata_n   = dmem_wdata;
                  rw_n      = dmem_rw;
                  grant_bad = |dmem_addr[31:ADDR_W+2];
               end else begin
                  owner_n   = GRANT_I;
                  addr_n    = imem_addr[ADDR_W+1:2];
                  wdata_n   = '0;
                  rw_n      = '0;
                  grant_bad = (|imem_addr[1:0]) || (|imem_addr[31:ADDR_W+2]);
               end
               last_grant_n = owner_n;
               cnt_n        = '0;
               if (grant_bad) begin
                  state_n    = RESP;
                  resp_err_n = 1'b1;
               end else begin
                  state_n    = ACCESS;
                  resp_err_n = 1'b0;
               end
            end
         end

         ACCESS: begin
            // An error wins even when the memory also claims ready.
            if (mem_error) begin
               state_n    = RESP;
               resp_err_n = 1'b1;
               rdata_n    = '0;
            end else if (mem_ready) begin
               state_n    = RESP;
               resp_err_n = 1'b0;
               rdata_n    = mem_rdata;
            end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
               state_n    = RESP;
               resp_err_n = 1'b1;
               rdata_n    = '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end

         RESP: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Outputs are pure decodes of registered state.
   assign mem_en     = (state_q == ACCESS);
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_rw     = rw_q;

   assign imem_ready = (state_q == RESP) && (owner_q == GRANT_I) && !resp_err_q;
   assign imem_error = (state_q == RESP) && (owner_q == GRANT_I) &&  resp_err_q;
   assign dmem_ready = (state_q == RESP) && (owner_q == GRANT_D) && !resp_err_q;
   assign dmem_error = (state_q == RESP) && (owner_q == GRANT_D) &&  resp_err_q;

   assign imem_rdata = rdata_q;
   assign dmem_rdata = rdata_q;

endmodule
